// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped UART transmitter on the core's data-memory bus. Stores to the
// TXDATA register queue a byte in a small FIFO. The FSM sends each queued byte
// as an 8N1 frame on txd. Loads from the STATUS register return the FIFO and
// FSM state. The top-level muxes RD into readData whenever sel is high.
//
// Register window (8 bytes at BASE_ADDR):
//   +0 TXDATA  write: WD[7:0] pushed when writeStrobe[0]=1; read: 0
//   +4 STATUS  read: [0]=busy [1]=full [2]=empty [3]=ovf [15:8]=count
//              write: writeStrobe[0] & WD[3] clears the sticky ovf flag
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   WE           store enable (memWrite)
//   writeStrobe  byte-lane enables of the store
//   A            data address (aluResult)
//   WD           store data
//   RD           combinational read data, 0 when sel=0
//   sel          combinational window decode
//   txd          registered serial output, idle high
//   irq_empty    registered: FIFO empty and transmitter idle
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [3:0]  writeStrobe,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        sel,
    output logic        txd,
    output logic        irq_empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [BW-1:0]   bcnt, bcnt_n;
    logic [2:0]      bitidx, bitidx_n;
    logic [7:0]      shiftreg, shift_n;
    logic            txd_n;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wrptr, rdptr;
    logic [CW-1:0]   count, count_n;
    logic            ovf;

    logic            empty, full, busy, bitdone;
    logic            push_req, clr_req, push_ok, ovf_set, pop;

    // The low address bits, the upper store lanes and the upper data bits are
    // don't-cares for this peripheral; they are gathered here on purpose.
    logic unused_bits;
    assign unused_bits = &{1'b0, A[1:0], writeStrobe[3:1], WD[31:8]};

    // Bus decode. Only lane 0 of a store carries the TX byte or the ovf clear.
    assign sel      = (A[31:3] == BASE_ADDR[31:3]);
    assign push_req = WE & sel & ~A[2] & writeStrobe[0];
    assign clr_req  = WE & sel &  A[2] & writeStrobe[0] & WD[3];

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign busy    = (state != IDLE);
    assign bitdone = (bcnt == BW'(CLKS_PER_BIT - 1));

    // A push into a full FIFO is still accepted when a pop frees a slot at
    // the same edge; only a truly blocked push is dropped and flagged.
    assign push_ok = push_req & (~full | pop);
    assign ovf_set = push_req & full & ~pop;

    // Status word is purely combinational so reads see the current state,
    // including the cleared FIFO while reset is held.
    always_comb begin
        RD = '0;
        if (sel && A[2]) begin
            RD[15:8] = 8'(count);
            RD[3]    = ovf;
            RD[2]    = empty;
            RD[1]    = full;
            RD[0]    = busy;
        end
    end

    // FIFO occupancy bookkeeping: count moves by push minus pop and can never
    // exceed the depth because blocked pushes are rejected above.
    always_comb begin
        count_n = count;
        case ({push_ok, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    // FIFO pointers, occupancy and the sticky overflow flag. A set wins over
    // a clear arriving at the same edge so no overflow is ever lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrptr <= '0;
            rdptr <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push_ok) wrptr <= wrptr + PW'(1);
            if (pop)     rdptr <= rdptr + PW'(1);
            count <= count_n;
            if (ovf_set)      ovf <= 1'b1;
            else if (clr_req) ovf <= 1'b0;
        end
    end

    // FIFO storage; data contents need no reset because occupancy guards them.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wrptr] <= WD[7:0];
    end

    // Transmitter next-state logic. Each of START, the eight DATA bits and
    // STOP occupies one full baud period. The last STOP cycle chains straight
    // into the next frame when a byte is waiting, so queued bytes go out with
    // no idle gap. txd is derived from the next state so the output flop lines
    // up with the state it represents.
    always_comb begin
        state_n  = state;
        bcnt_n   = bcnt;
        bitidx_n = bitidx;
        shift_n  = shiftreg;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                    bcnt_n  = '0;
                    shift_n = mem[rdptr];
                end
            end
            START: begin
                if (bitdone) begin
                    state_n  = DATA;
                    bcnt_n   = '0;
                    bitidx_n = '0;
                end else begin
                    bcnt_n = bcnt + BW'(1);
                end
            end
            DATA: begin
                if (bitdone) begin
                    bcnt_n  = '0;
                    shift_n = shiftreg >> 1;
                    if (bitidx == 3'd7) state_n  = STOP;
                    else                bitidx_n = bitidx + 3'd1;
                end else begin
                    bcnt_n = bcnt + BW'(1);
                end
            end
            STOP: begin
                if (bitdone) begin
                    bcnt_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = START;
                        shift_n = mem[rdptr];
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    bcnt_n = bcnt + BW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                bcnt_n  = '0;
            end
        endcase

        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end

    // Transmitter registers. Reset drops the line back to idle-high at once,
    // even in the middle of a frame. irq_empty tracks the next values so it
    // agrees with the FSM and FIFO flops in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bcnt      <= '0;
            bitidx    <= '0;
            shiftreg  <= '0;
            txd       <= 1'b1;
            irq_empty <= 1'b1;
        end else begin
            state     <= state_n;
            bcnt      <= bcnt_n;
            bitidx    <= bitidx_n;
            shiftreg  <= shift_n;
            txd       <= txd_n;
            irq_empty <= (count_n == '0) && (state_n == IDLE);
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart_tx
// Bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=8. A frame-level
// reference model (queue of pending bytes plus the byte currently on the line
// and the cycles elapsed in its frame) predicts txd, irq_empty, sel and RD.
// -----------------------------------------------------------------------------
module tb_mmio_uart_tx;

    localparam int          C    = 4;
    localparam int          D    = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [3:0]  writeStrobe;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        sel;
    logic        txd;
    logic        irq_empty;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    bit         active = 1'b0;
    logic [7:0] fbyte  = 8'h00;
    int         elapsed = 0;
    bit         movf   = 1'b0;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .WE         (WE),
        .writeStrobe(writeStrobe),
        .A          (A),
        .WD         (WD),
        .RD         (RD),
        .sel        (sel),
        .txd        (txd),
        .irq_empty  (irq_empty)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Line level of an 8N1 frame at the current point of the model's timeline.
    function automatic logic expTxd();
        int b;
        if (!active) return 1'b1;
        b = elapsed / C;
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return fbyte[b-1];
    endfunction

    // Expected read data for an address, from the model's FIFO and line state.
    function automatic logic [31:0] expRd(input logic [31:0] addr);
        logic [31:0] r;
        r = '0;
        if (addr[31:3] == BASE[31:3] && addr[2]) begin
            r[15:8] = 8'(q.size());
            r[3]    = movf;
            r[2]    = (q.size() == 0);
            r[1]    = (q.size() == D);
            r[0]    = active;
        end
        return r;
    endfunction

    // Model update for one clock edge using the bus inputs held across it.
    task automatic modelEdge();
        int pre;
        bit popNow, pushReq, clrReq, ovfSet, hit;
        pre     = q.size();
        popNow  = 1'b0;
        ovfSet  = 1'b0;
        hit     = (A[31:3] == BASE[31:3]);
        pushReq = WE && hit && !A[2] && writeStrobe[0];
        clrReq  = WE && hit &&  A[2] && writeStrobe[0] && WD[3];
        if (active && elapsed == 10*C - 1) begin
            if (pre > 0) popNow = 1'b1;
            else         active = 1'b0;
        end else if (active) begin
            elapsed++;
        end else if (pre > 0) begin
            popNow = 1'b1;
        end
        if (popNow) begin
            fbyte   = q.pop_front();
            active  = 1'b1;
            elapsed = 0;
        end
        if (pushReq) begin
            if (pre < D || popNow) q.push_back(WD[7:0]);
            else                   ovfSet = 1'b1;
        end
        if (ovfSet)      movf = 1'b1;
        else if (clrReq) movf = 1'b0;
    endtask

    task automatic modelReset();
        q.delete();
        active  = 1'b0;
        elapsed = 0;
        movf    = 1'b0;
    endtask

    // One bus cycle: drive inputs, take the edge, then check all outputs.
    task automatic applyStimulus(input logic we, input logic [3:0] strb,
                                 input logic [31:0] addr, input logic [31:0] wd);
        WE          = we;
        writeStrobe = strb;
        A           = addr;
        WD          = wd;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("txd",       {31'b0, txd},       {31'b0, expTxd()});
        checkOutput("irq_empty", {31'b0, irq_empty}, {31'b0, (!active && q.size() == 0)});
        checkOutput("sel",       {31'b0, sel},       {31'b0, (addr[31:3] == BASE[31:3])});
        checkOutput("rd",        RD,                 expRd(addr));
    endtask

    task automatic idleCycles(input int n, input logic [31:0] addr);
        repeat (n) applyStimulus(1'b0, 4'b0000, addr, 32'h0);
    endtask

    initial begin
        logic [31:0] addr;
        reset = 1'b1;
        WE = 1'b0; writeStrobe = 4'b0; A = BASE + 32'd4; WD = 32'h0;
        #22;
        checkOutput("reset_status", RD, 32'h0000_0004);
        checkOutput("reset_txd", {31'b0, txd}, 32'h1);
        checkOutput("reset_irq", {31'b0, irq_empty}, 32'h1);
        reset = 1'b0;
        modelReset();

        // Single frame of 0x55.
        applyStimulus(1'b1, 4'b0001, BASE, 32'h55);
        idleCycles(45, BASE + 32'd4);
        checkOutput("after_55_status", RD, 32'h0000_0004);
        checkOutput("after_55_irq", {31'b0, irq_empty}, 32'h1);

        // Wrong lane and out-of-window stores do nothing.
        applyStimulus(1'b1, 4'b0010, BASE, 32'hAB);
        idleCycles(3, BASE + 32'd4);
        checkOutput("strobe_nopush", RD, 32'h0000_0004);
        applyStimulus(1'b1, 4'b0001, BASE + 32'd8, 32'h77);
        checkOutput("base8_sel", {31'b0, sel}, 32'h0);
        checkOutput("base8_rd", RD, 32'h0);
        idleCycles(3, BASE + 32'd4);
        checkOutput("base8_nopush", RD, 32'h0000_0004);

        // Keep the line busy, then overfill the FIFO.
        applyStimulus(1'b1, 4'b0001, BASE, 32'hFF);
        for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 4'b0001, BASE, 32'(i));
        idleCycles(1, BASE + 32'd4);
        checkOutput("ovf_flag", {31'b0, RD[3]}, 32'h1);
        checkOutput("ovf_count", {24'b0, RD[15:8]}, 32'h8);
        applyStimulus(1'b1, 4'b0001, BASE + 32'd4, 32'h8);
        checkOutput("ovf_clear", {31'b0, RD[3]}, 32'h0);
        idleCycles(9*10*C + 20, BASE + 32'd4);
        checkOutput("drain_status", RD, 32'h0000_0004);

        // Two bytes queued behind an active frame.
        applyStimulus(1'b1, 4'b0001, BASE, 32'h11);
        applyStimulus(1'b1, 4'b0001, BASE, 32'h22);
        applyStimulus(1'b1, 4'b0001, BASE, 32'h33);
        applyStimulus(1'b0, 4'b0000, BASE + 32'd4, 32'h0);
        checkOutput("queued2_status", RD, 32'h0000_0201);
        idleCycles(3*10*C + 10, BASE + 32'd4);

        // Reset in the middle of the data bits of 0xA3 with three bytes queued.
        applyStimulus(1'b1, 4'b0001, BASE, 32'hA3);
        applyStimulus(1'b1, 4'b0001, BASE, 32'h11);
        applyStimulus(1'b1, 4'b0001, BASE, 32'h22);
        applyStimulus(1'b1, 4'b0001, BASE, 32'h33);
        idleCycles(8, BASE + 32'd4);
        checkOutput("pre_reset_status", RD, 32'h0000_0301);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_txd", {31'b0, txd}, 32'h1);
        checkOutput("midreset_status", RD, 32'h0000_0004);
        checkOutput("midreset_irq", {31'b0, irq_empty}, 32'h1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        modelReset();
        idleCycles(60, BASE + 32'd4);
        checkOutput("post_reset_status", RD, 32'h0000_0004);

        // Random bus traffic against the model.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    addr = BASE;
                2:       addr = BASE + 32'd4;
                default: addr = BASE + 32'd8;
            endcase
            addr[1:0] = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), addr, $urandom);
        end
        idleCycles(D*10*C + 60, BASE + 32'd4);
        checkOutput("random_drain", {31'b0, irq_empty}, 32'h1);

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
